// File: rtl/lagartoII_pkg.sv
// Shared LagartoII front-end definitions: widths, word/address types, reset constants
// and the action codes that steer the IF/ID register.
package lagartoII_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam addr_t RESET_PC = '0;
    localparam word_t NOP_WORD = '0;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2,
        IFID_FLUSH  = 2'd3
    } ifid_op_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid bit plus instruction and PC fields, steered by a
// single action code (hold, load, bubble, flush).
module if_id_reg #(
    parameter int                ADDR_W   = lagartoII_pkg::ADDR_W,
    parameter int                DATA_W   = lagartoII_pkg::DATA_W,
    parameter logic [DATA_W-1:0] NOP_WORD = lagartoII_pkg::NOP_WORD
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  lagartoII_pkg::ifid_op_e  op,
    input  logic [DATA_W-1:0]        instrIn,
    input  logic [ADDR_W-1:0]        pcIn,
    output logic                     validP1,
    output logic [DATA_W-1:0]        instrP1,
    output logic [ADDR_W-1:0]        pcP1
);
    import lagartoII_pkg::*;

    // IF -> ID stage boundary
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            validP1 <= 1'b0;
            instrP1 <= NOP_WORD;
            pcP1    <= '0;
        end else begin
            unique case (op)
                IFID_LOAD: begin
                    validP1 <= 1'b1;
                    instrP1 <= instrIn;
                    pcP1    <= pcIn;
                end
                // An invalid slot always shows the NOP word; pc field keeps its last value.
                IFID_BUBBLE, IFID_FLUSH: begin
                    validP1 <= 1'b0;
                    instrP1 <= NOP_WORD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// LagartoII instruction fetch: PC register, next-PC selection, IF/ID handoff to decode
// with a valid/ready handshake, and a count of words accepted by decode.
module if_fetch_stage #(
    parameter int                ADDR_W   = lagartoII_pkg::ADDR_W,
    parameter int                DATA_W   = lagartoII_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = lagartoII_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] NOP_WORD = lagartoII_pkg::NOP_WORD
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              if_valid_o,
    input  logic              if_ready_i,
    output logic [DATA_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [ADDR_W-1:0] if_pc_next_o,
    output logic [31:0]       fetch_cnt_o
);
    import lagartoII_pkg::*;

    logic [ADDR_W-1:0] pcP0;
    logic [31:0]       fetchCnt;
    logic              loadSlot;
    logic              accept;
    ifid_op_e          ifidOp;

    // The slot can take a new word when it is empty or being drained this cycle.
    assign loadSlot = !if_valid_o || if_ready_i;
    assign accept   = if_valid_o && if_ready_i && !redirect_i;

    always_comb begin
        ifidOp = IFID_HOLD;
        if (redirect_i)
            ifidOp = IFID_FLUSH;
        else if (loadSlot)
            ifidOp = en_i ? IFID_LOAD : IFID_BUBBLE;
    end

    // PC stage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pcP0     <= RESET_PC;
            fetchCnt <= '0;
        end else begin
            if (redirect_i)
                pcP0 <= redirect_pc_i;
            else if (loadSlot && en_i)
                pcP0 <= pcP0 + ADDR_W'(1);
            if (accept)
                fetchCnt <= fetchCnt + 32'd1;
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .op      (ifidOp),
        .instrIn (imem_data_i),
        .pcIn    (pcP0),
        .validP1 (if_valid_o),
        .instrP1 (if_instr_o),
        .pcP1    (if_pc_o)
    );

    assign imem_addr_o  = pcP0;
    assign if_pc_next_o = if_pc_o + ADDR_W'(1);
    assign fetch_cnt_o  = fetchCnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: word memory k = 0x1000_0000+k, a per-cycle reference model
// of the fetch rules, and directed scenarios with literal expectations.
module tb_if_fetch_stage;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              en_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_data_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              if_valid_o;
    logic              if_ready_i;
    logic [DATA_W-1:0] if_instr_o;
    logic [ADDR_W-1:0] if_pc_o;
    logic [ADDR_W-1:0] if_pc_next_o;
    logic [31:0]       fetch_cnt_o;

    logic [DATA_W-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    assign imem_data_i = mem[imem_addr_o];

    if_fetch_stage #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (12'h000),
        .NOP_WORD (32'h0)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_pc_next_o  (if_pc_next_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    function automatic logic [31:0] wordAt(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage must hold after each edge, from the fetch rules.
    logic              modelOn = 1'b0;
    logic [ADDR_W-1:0] mPc;
    logic              mValid;
    logic [31:0]       mInstr;
    logic [ADDR_W-1:0] mPcOut;
    logic [31:0]       mCnt;

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            modelOn = 1'b1;
            mPc = 12'h000; mValid = 1'b0; mInstr = 32'h0; mPcOut = 12'h000; mCnt = 32'h0;
        end else if (modelOn) begin
            if (mValid && if_ready_i && !redirect_i) mCnt = mCnt + 1;
            if (redirect_i) begin
                mPc = redirect_pc_i; mValid = 1'b0; mInstr = 32'h0;
            end else if (!mValid || if_ready_i) begin
                if (en_i) begin
                    mInstr = wordAt(mPc); mPcOut = mPc; mValid = 1'b1;
                    mPc = 12'((int'(mPc) + 1) % DEPTH);
                end else begin
                    mValid = 1'b0; mInstr = 32'h0;
                end
            end
        end
        #1;
        if (modelOn) begin
            chk("model_valid", {31'b0, if_valid_o}, {31'b0, mValid});
            chk("model_instr", if_instr_o, mInstr);
            chk("model_pc", 32'(if_pc_o), 32'(mPcOut));
            chk("model_pc_next", 32'(if_pc_next_o), 32'((int'(mPcOut) + 1) % DEPTH));
            chk("model_imem_addr", 32'(imem_addr_o), 32'(mPc));
            chk("model_cnt", fetch_cnt_o, mCnt);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = 32'h1000_0000 + 32'(k);
        rst_ni = 1'b0; en_i = 1'b1; if_ready_i = 1'b1;
        redirect_i = 1'b0; redirect_pc_i = '0;

        // 1: straight-line streaming from reset
        doReset();
        chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("rst_instr", if_instr_o, 32'h0);
        chk("rst_pc", 32'(if_pc_o), 32'd0);
        chk("rst_cnt", fetch_cnt_o, 32'd0);
        chk("rst_addr", 32'(imem_addr_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t1_pc", 32'(if_pc_o), 32'(k));
            chk("t1_instr", if_instr_o, 32'h1000_0000 + 32'(k));
        end
        cyc();
        chk("t1_cnt", fetch_cnt_o, 32'd5);

        // 2: decode stall while pc 2 is offered
        doReset();
        cyc(); cyc(); cyc();
        chk("t2_pc_before", 32'(if_pc_o), 32'd2);
        if_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t2_hold_instr", if_instr_o, 32'h1000_0002);
            chk("t2_hold_pc", 32'(if_pc_o), 32'd2);
            chk("t2_hold_valid", {31'b0, if_valid_o}, 32'd1);
        end
        if_ready_i = 1'b1;
        cyc();
        chk("t2_resume_pc", 32'(if_pc_o), 32'd3);
        chk("t2_resume_cnt", fetch_cnt_o, 32'd3);

        // 3: redirect during stall flushes without counting
        redirect_i = 1'b1; redirect_pc_i = 12'h100; if_ready_i = 1'b0;
        cyc();
        chk("t3_flush_valid", {31'b0, if_valid_o}, 32'd0);
        chk("t3_flush_instr", if_instr_o, 32'h0);
        chk("t3_flush_cnt", fetch_cnt_o, 32'd3);
        redirect_i = 1'b0; if_ready_i = 1'b1;
        cyc();
        chk("t3_target_pc", 32'(if_pc_o), 32'h100);
        chk("t3_target_instr", if_instr_o, 32'h1000_0100);
        chk("t3_target_cnt", fetch_cnt_o, 32'd3);

        // 4: PC wrap at the top of the address space
        redirect_i = 1'b1; redirect_pc_i = 12'hFFE;
        cyc();
        redirect_i = 1'b0;
        cyc();
        chk("t4_pc_ffe", 32'(if_pc_o), 32'hFFE);
        cyc();
        chk("t4_pc_fff", 32'(if_pc_o), 32'hFFF);
        chk("t4_next_wrap", 32'(if_pc_next_o), 32'h000);
        cyc();
        chk("t4_pc_000", 32'(if_pc_o), 32'h000);
        chk("t4_instr_000", if_instr_o, 32'h1000_0000);

        // 5: fetch disable mid-stream
        en_i = 1'b0;
        cyc();
        chk("t5_drain_valid", {31'b0, if_valid_o}, 32'd0);
        cyc();
        chk("t5_frozen_addr", 32'(imem_addr_o), 32'd1);
        en_i = 1'b1;
        cyc();
        chk("t5_resume_pc", 32'(if_pc_o), 32'd1);
        chk("t5_resume_instr", if_instr_o, 32'h1000_0001);

        // 6: reset during a stall that follows a redirect
        redirect_i = 1'b1; redirect_pc_i = 12'h200; if_ready_i = 1'b0;
        cyc();
        redirect_i = 1'b0;
        cyc();
        chk("t6_stalled_pc", 32'(if_pc_o), 32'h200);
        rst_ni = 1'b0;
        cyc();
        chk("t6_rst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("t6_rst_instr", if_instr_o, 32'h0);
        chk("t6_rst_pc", 32'(if_pc_o), 32'd0);
        chk("t6_rst_cnt", fetch_cnt_o, 32'd0);
        chk("t6_rst_addr", 32'(imem_addr_o), 32'd0);
        rst_ni = 1'b1; if_ready_i = 1'b1;
        cyc();
        chk("t6_first_valid", {31'b0, if_valid_o}, 32'd1);
        chk("t6_first_pc", 32'(if_pc_o), 32'd0);
        chk("t6_first_instr", if_instr_o, 32'h1000_0000);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, time %0t expected under 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
